// File: rtl/output_access_arbiter_if.sv
// Bundle of requester handshake signals and the output-register bit port.
// The arbiter uses the slave modport; requesters and the register use master.
interface output_access_arbiter_if #(
    parameter int unsigned NUM_REQ  = 3,
    parameter int unsigned ADDR_LEN = 4
) ();
    logic [NUM_REQ-1:0]          req;
    logic [NUM_REQ-1:0]          req_rw;
    logic [NUM_REQ*ADDR_LEN-1:0] req_addr;
    logic [NUM_REQ-1:0]          req_wdata;
    logic [NUM_REQ-1:0]          ack;
    logic                        ack_rdata;
    logic                        ack_err;
    logic                        busy;
    logic                        out_rw;
    logic [ADDR_LEN-1:0]         out_addr;
    logic                        out_wdata;
    logic                        out_rdata;

    modport slave (
        input  req, req_rw, req_addr, req_wdata, out_rdata,
        output ack, ack_rdata, ack_err, busy, out_rw, out_addr, out_wdata
    );

    modport master (
        output req, req_rw, req_addr, req_wdata, out_rdata,
        input  ack, ack_rdata, ack_err, busy, out_rw, out_addr, out_wdata
    );
endinterface

// File: rtl/output_access_arbiter.sv
// Round-robin arbiter that serialises single-bit reads/writes from NUM_REQ requesters
// onto the output register's bit port, with fully registered, glitch-free bus outputs.
module output_access_arbiter #(
    parameter int unsigned NUM_REQ  = 3,
    parameter int unsigned ADDR_LEN = 4,
    parameter int unsigned OUT_NUM  = 16
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    output_access_arbiter_if.slave bus
);
    localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {StIdle, StRead, StWrite, StDone} state_t;

    state_t              r_state;
    logic [IDX_W-1:0]    r_rr_ptr;
    logic [IDX_W-1:0]    r_gnt;
    logic [NUM_REQ-1:0]  r_ack;
    logic                r_ack_rdata;
    logic                r_ack_err;
    logic                r_busy;
    logic                r_out_rw;
    logic [ADDR_LEN-1:0] r_out_addr;
    logic                r_out_wdata;

    logic                w_any;
    logic [IDX_W-1:0]    w_gnt;
    logic [IDX_W-1:0]    w_cand;
    logic [ADDR_LEN-1:0] w_addr;
    logic                w_rw;
    logic                w_wdata;
    logic                w_illegal;
    logic [NUM_REQ-1:0]  w_gnt_oh;
    logic [NUM_REQ-1:0]  w_cur_oh;
    logic [IDX_W-1:0]    w_next_ptr;

    // First set request at or above the rotating pointer, wrapping modulo NUM_REQ.
    always_comb begin
        w_any  = 1'b0;
        w_gnt  = '0;
        w_cand = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            w_cand = IDX_W'((32'(r_rr_ptr) + k) % NUM_REQ);
            if (!w_any && bus.req[w_cand]) begin
                w_any = 1'b1;
                w_gnt = w_cand;
            end
        end
    end

    assign w_addr     = bus.req_addr[32'(w_gnt) * ADDR_LEN +: ADDR_LEN];
    assign w_rw       = bus.req_rw[w_gnt];
    assign w_wdata    = bus.req_wdata[w_gnt];
    assign w_illegal  = (32'(w_addr) >= OUT_NUM);
    assign w_gnt_oh   = NUM_REQ'(1) << w_gnt;
    assign w_cur_oh   = NUM_REQ'(1) << r_gnt;
    assign w_next_ptr = (r_gnt == IDX_W'(NUM_REQ - 1)) ? '0 : r_gnt + IDX_W'(1);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= StIdle;
            r_rr_ptr    <= '0;
            r_gnt       <= '0;
            r_ack       <= '0;
            r_ack_rdata <= 1'b0;
            r_ack_err   <= 1'b0;
            r_busy      <= 1'b0;
            r_out_rw    <= 1'b1;
            r_out_addr  <= '0;
            r_out_wdata <= 1'b0;
        end else begin
            // ack and ack_err are single-cycle pulses unless set below.
            r_ack     <= '0;
            r_ack_err <= 1'b0;
            unique case (r_state)
                StIdle: begin
                    if (w_any) begin
                        r_gnt  <= w_gnt;
                        r_busy <= 1'b1;
                        if (w_illegal) begin
                            r_ack     <= w_gnt_oh;
                            r_ack_err <= 1'b1;
                            r_state   <= StDone;
                        end else if (w_rw) begin
                            r_out_addr <= w_addr;
                            r_state    <= StRead;
                        end else begin
                            r_out_addr  <= w_addr;
                            r_out_wdata <= w_wdata;
                            r_out_rw    <= 1'b0;
                            r_state     <= StWrite;
                        end
                    end
                end
                StRead: begin
                    r_ack_rdata <= bus.out_rdata;
                    r_ack       <= w_cur_oh;
                    r_state     <= StDone;
                end
                StWrite: begin
                    // Address and data hold while the write strobe is released.
                    r_out_rw <= 1'b1;
                    r_ack    <= w_cur_oh;
                    r_state  <= StDone;
                end
                StDone: begin
                    r_rr_ptr <= w_next_ptr;
                    r_busy   <= 1'b0;
                    r_state  <= StIdle;
                end
                default: begin
                    r_state <= StIdle;
                end
            endcase
        end
    end

    assign bus.ack       = r_ack;
    assign bus.ack_rdata = r_ack_rdata;
    assign bus.ack_err   = r_ack_err;
    assign bus.busy      = r_busy;
    assign bus.out_rw    = r_out_rw;
    assign bus.out_addr  = r_out_addr;
    assign bus.out_wdata = r_out_wdata;

    a_ack_onehot : assert property (@(posedge i_clk) disable iff (!i_rst_n) $onehot0(r_ack));
    a_write_one_cycle : assert property (@(posedge i_clk) disable iff (!i_rst_n)
        !r_out_rw |=> r_out_rw);
    a_write_stable : assert property (@(posedge i_clk) disable iff (!i_rst_n)
        !r_out_rw |=> ($stable(r_out_addr) && $stable(r_out_wdata)));
endmodule

// File: tb/tb_output_access_arbiter.sv
// Scenario bench for output_access_arbiter: scoreboard of expected acks plus a
// behavioural output register attached to the bit port.
module tb_output_access_arbiter;
    localparam int unsigned NUM_REQ  = 3;
    localparam int unsigned ADDR_LEN = 4;
    localparam int unsigned OUT_NUM  = 12;
    localparam int          BUDGET   = 20;

    typedef struct {
        int   idx;
        logic rdata;
        logic chk_rd;
        logic err;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    output_access_arbiter_if #(.NUM_REQ(NUM_REQ), .ADDR_LEN(ADDR_LEN)) bus ();

    output_access_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ADDR_LEN(ADDR_LEN),
        .OUT_NUM (OUT_NUM)
    ) dut (
        .i_clk  (clk),
        .i_rst_n(rst_n),
        .bus    (bus)
    );

    // Output register: writes on every edge where out_rw is low.
    logic [15:0] reg_bits    = '0;
    int          n_wr_pulses = 0;
    always @(posedge clk) begin
        if (bus.out_rw === 1'b0) begin
            reg_bits[bus.out_addr] <= bus.out_wdata;
            n_wr_pulses            <= n_wr_pulses + 1;
        end
    end
    assign bus.out_rdata = reg_bits[bus.out_addr];

    exp_t               exp_q[$];
    logic [15:0]        exp_mem   = '0;
    logic [ADDR_LEN-1:0] last_addr = '0;
    logic               last_rdata = 1'b0;
    int                 n_checks  = 0;
    int                 n_fail    = 0;

    task automatic set_req(input int i, input logic rw, input logic [ADDR_LEN-1:0] a,
                           input logic wd);
        bus.req[i]                          = 1'b1;
        bus.req_rw[i]                       = rw;
        bus.req_addr[i*ADDR_LEN +: ADDR_LEN] = a;
        bus.req_wdata[i]                    = wd;
    endtask

    task automatic wait_ack(output logic [NUM_REQ-1:0] a, output logic rd, output logic er,
                            output int waited);
        a = '0; rd = 1'b0; er = 1'b0; waited = 0;
        for (int c = 0; c < BUDGET; c++) begin
            @(negedge clk);
            waited = c + 1;
            if (bus.ack !== '0) begin
                a  = bus.ack;
                rd = bus.ack_rdata;
                er = bus.ack_err;
                break;
            end
        end
    endtask

    task automatic test_reset();
        bus.req = '0; bus.req_rw = '0; bus.req_addr = '0; bus.req_wdata = '0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++; if (bus.ack !== '0) begin n_fail++;
            $display("FAIL reset_ack: got %b want 000", bus.ack); end
        n_checks++; if (bus.ack_err !== 1'b0) begin n_fail++;
            $display("FAIL reset_ack_err: got %b want 0", bus.ack_err); end
        n_checks++; if (bus.ack_rdata !== 1'b0) begin n_fail++;
            $display("FAIL reset_ack_rdata: got %b want 0", bus.ack_rdata); end
        n_checks++; if (bus.busy !== 1'b0) begin n_fail++;
            $display("FAIL reset_busy: got %b want 0", bus.busy); end
        n_checks++; if (bus.out_rw !== 1'b1) begin n_fail++;
            $display("FAIL reset_out_rw: got %b want 1", bus.out_rw); end
        n_checks++; if (bus.out_addr !== '0) begin n_fail++;
            $display("FAIL reset_out_addr: got %0d want 0", bus.out_addr); end
        n_checks++; if (bus.out_wdata !== 1'b0) begin n_fail++;
            $display("FAIL reset_out_wdata: got %b want 0", bus.out_wdata); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_write_read();
        logic [NUM_REQ-1:0] a, exp_ack;
        logic rd, er;
        int   waited, wr0;
        exp_t e;
        set_req(0, 1'b0, 4'd5, 1'b1);
        exp_mem[5] = 1'b1; last_addr = 4'd5; wr0 = n_wr_pulses;
        exp_q.push_back('{0, 1'b0, 1'b0, 1'b0});
        @(negedge clk);
        n_checks++; if (bus.out_rw !== 1'b0 || bus.out_addr !== 4'd5 || bus.out_wdata !== 1'b1)
            begin n_fail++; $display("FAIL wr_bus: got rw=%b addr=%0d wd=%b want rw=0 addr=5 wd=1",
                bus.out_rw, bus.out_addr, bus.out_wdata); end
        n_checks++; if (bus.busy !== 1'b1) begin n_fail++;
            $display("FAIL wr_busy: got %b want 1", bus.busy); end
        @(negedge clk);
        e = exp_q.pop_front(); exp_ack = '0; exp_ack[e.idx] = 1'b1;
        n_checks++; if (bus.ack !== exp_ack || bus.ack_err !== e.err) begin n_fail++;
            $display("FAIL wr_ack: got ack=%b err=%b want ack=%b err=%b",
                bus.ack, bus.ack_err, exp_ack, e.err); end
        n_checks++; if (bus.out_rw !== 1'b1 || n_wr_pulses - wr0 != 1) begin n_fail++;
            $display("FAIL wr_pulse: got rw=%b pulses=%0d want rw=1 pulses=1",
                bus.out_rw, n_wr_pulses - wr0); end
        bus.req[0] = 1'b0;
        @(negedge clk);
        set_req(0, 1'b1, 4'd5, 1'b0);
        exp_q.push_back('{0, exp_mem[5], 1'b1, 1'b0});
        wait_ack(a, rd, er, waited);
        bus.req[0] = 1'b0;
        e = exp_q.pop_front(); exp_ack = '0; exp_ack[e.idx] = 1'b1;
        n_checks++; if (a !== exp_ack || er !== e.err || rd !== e.rdata) begin n_fail++;
            $display("FAIL rd_ack: got ack=%b err=%b rd=%b want ack=%b err=%b rd=%b",
                a, er, rd, exp_ack, e.err, e.rdata); end
        n_checks++; if (waited != 2) begin n_fail++;
            $display("FAIL rd_latency: got %0d want 2", waited); end
        last_rdata = e.rdata;
        @(negedge clk);
    endtask

    task automatic test_contention();
        logic [NUM_REQ-1:0] a, exp_ack;
        logic rd, er;
        int   waited;
        exp_t e;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        set_req(0, 1'b1, 4'd5, 1'b0);
        set_req(1, 1'b1, 4'd0, 1'b0);
        set_req(2, 1'b1, 4'd5, 1'b0);
        for (int k = 0; k < 6; k++)
            exp_q.push_back('{k % 3, exp_mem[(k % 3 == 1) ? 0 : 5], 1'b1, 1'b0});
        for (int k = 0; k < 6; k++) begin
            wait_ack(a, rd, er, waited);
            e = exp_q.pop_front(); exp_ack = '0; exp_ack[e.idx] = 1'b1;
            n_checks++; if (a !== exp_ack || er !== e.err || rd !== e.rdata) begin n_fail++;
                $display("FAIL contention_ack%0d: got ack=%b err=%b rd=%b want ack=%b err=%b rd=%b",
                    k, a, er, rd, exp_ack, e.err, e.rdata); end
            n_checks++; if (waited != ((k == 0) ? 2 : 3)) begin n_fail++;
                $display("FAIL contention_spacing%0d: got %0d want %0d",
                    k, waited, (k == 0) ? 2 : 3); end
            last_rdata = e.rdata;
        end
        bus.req = '0;
        last_addr = 4'd5;
        @(negedge clk);
    endtask

    task automatic test_illegal();
        logic [NUM_REQ-1:0] a, exp_ack;
        logic rd, er;
        int   waited, wr0;
        exp_t e;
        set_req(1, 1'b1, 4'd13, 1'b0);
        exp_q.push_back('{1, 1'b0, 1'b0, 1'b1});
        wait_ack(a, rd, er, waited);
        bus.req[1] = 1'b0;
        e = exp_q.pop_front(); exp_ack = '0; exp_ack[e.idx] = 1'b1;
        n_checks++; if (a !== exp_ack || er !== e.err) begin n_fail++;
            $display("FAIL illegal_ack: got ack=%b err=%b want ack=%b err=%b",
                a, er, exp_ack, e.err); end
        n_checks++; if (waited != 1) begin n_fail++;
            $display("FAIL illegal_latency: got %0d want 1", waited); end
        n_checks++; if (bus.out_rw !== 1'b1 || bus.out_addr !== last_addr) begin n_fail++;
            $display("FAIL illegal_bus: got rw=%b addr=%0d want rw=1 addr=%0d",
                bus.out_rw, bus.out_addr, last_addr); end
        @(negedge clk);
        n_checks++; if (bus.ack_err !== 1'b0 || bus.ack_rdata !== last_rdata) begin n_fail++;
            $display("FAIL illegal_after: got err=%b rd=%b want err=0 rd=%b",
                bus.ack_err, bus.ack_rdata, last_rdata); end
        // First illegal address, as a write: must not touch the register.
        wr0 = n_wr_pulses;
        set_req(2, 1'b0, 4'd12, 1'b1);
        exp_q.push_back('{2, 1'b0, 1'b0, 1'b1});
        wait_ack(a, rd, er, waited);
        bus.req[2] = 1'b0;
        e = exp_q.pop_front(); exp_ack = '0; exp_ack[e.idx] = 1'b1;
        n_checks++; if (a !== exp_ack || er !== e.err || waited != 1) begin n_fail++;
            $display("FAIL illegal12_ack: got ack=%b err=%b lat=%0d want ack=%b err=%b lat=1",
                a, er, waited, exp_ack, e.err); end
        n_checks++; if (n_wr_pulses != wr0) begin n_fail++;
            $display("FAIL illegal12_write: got %0d pulses want 0", n_wr_pulses - wr0); end
        @(negedge clk);
        // Last legal address.
        set_req(1, 1'b0, 4'd11, 1'b1);
        exp_mem[11] = 1'b1; last_addr = 4'd11;
        exp_q.push_back('{1, 1'b0, 1'b0, 1'b0});
        wait_ack(a, rd, er, waited);
        bus.req[1] = 1'b0;
        e = exp_q.pop_front(); exp_ack = '0; exp_ack[e.idx] = 1'b1;
        n_checks++; if (a !== exp_ack || er !== e.err || waited != 2) begin n_fail++;
            $display("FAIL legal11_ack: got ack=%b err=%b lat=%0d want ack=%b err=%b lat=2",
                a, er, waited, exp_ack, e.err); end
        @(negedge clk);
    endtask

    task automatic test_glitch();
        logic [NUM_REQ-1:0] a, exp_ack;
        logic rd, er;
        int   waited;
        exp_t e;
        set_req(0, 1'b0, 4'd3, 1'b1);
        exp_mem[3] = 1'b1; last_addr = 4'd3;
        exp_q.push_back('{0, 1'b0, 1'b0, 1'b0});
        @(negedge clk);
        n_checks++; if (bus.out_rw !== 1'b0 || bus.out_addr !== 4'd3) begin n_fail++;
            $display("FAIL glitch_write: got rw=%b addr=%0d want rw=0 addr=3",
                bus.out_rw, bus.out_addr); end
        bus.req_addr[0 +: ADDR_LEN] = 4'd9;
        bus.req_wdata[0]            = 1'b0;
        @(negedge clk);
        e = exp_q.pop_front(); exp_ack = '0; exp_ack[e.idx] = 1'b1;
        n_checks++; if (bus.ack !== exp_ack || bus.out_addr !== 4'd3) begin n_fail++;
            $display("FAIL glitch_ack: got ack=%b addr=%0d want ack=%b addr=3",
                bus.ack, bus.out_addr, exp_ack); end
        bus.req[0] = 1'b0;
        @(negedge clk);
        // Read back both bits; pointer now favours requester 1.
        set_req(0, 1'b1, 4'd3, 1'b0);
        set_req(1, 1'b1, 4'd9, 1'b0);
        exp_q.push_back('{1, exp_mem[9], 1'b1, 1'b0});
        exp_q.push_back('{0, exp_mem[3], 1'b1, 1'b0});
        for (int k = 0; k < 2; k++) begin
            wait_ack(a, rd, er, waited);
            bus.req = bus.req & ~a;
            e = exp_q.pop_front(); exp_ack = '0; exp_ack[e.idx] = 1'b1;
            n_checks++; if (a !== exp_ack || rd !== e.rdata || waited != 2 + k) begin n_fail++;
                $display("FAIL glitch_readback%0d: got ack=%b rd=%b lat=%0d want ack=%b rd=%b lat=%0d",
                    k, a, rd, waited, exp_ack, e.rdata, 2 + k); end
            last_rdata = e.rdata;
        end
        bus.req = '0;
        last_addr = 4'd3;
        @(negedge clk);
    endtask

    task automatic test_reset_mid_write();
        logic [NUM_REQ-1:0] a, exp_ack;
        logic rd, er;
        int   waited;
        exp_t e;
        set_req(0, 1'b0, 4'd7, 1'b1);
        @(negedge clk);
        n_checks++; if (bus.out_rw !== 1'b0) begin n_fail++;
            $display("FAIL rstmid_in_write: got rw=%b want 0", bus.out_rw); end
        rst_n = 1'b0;
        #1;
        n_checks++; if (bus.out_rw !== 1'b1 || bus.ack !== '0 || bus.busy !== 1'b0 ||
                        bus.out_addr !== '0) begin n_fail++;
            $display("FAIL rstmid_async: got rw=%b ack=%b busy=%b addr=%0d want rw=1 ack=000 busy=0 addr=0",
                bus.out_rw, bus.ack, bus.busy, bus.out_addr); end
        bus.req = '0;
        set_req(2, 1'b1, 4'd11, 1'b0);
        repeat (2) @(negedge clk);
        n_checks++; if (bus.ack !== '0 || bus.busy !== 1'b0) begin n_fail++;
            $display("FAIL rstmid_held: got ack=%b busy=%b want ack=000 busy=0", bus.ack, bus.busy); end
        rst_n = 1'b1;
        exp_q.push_back('{2, exp_mem[11], 1'b1, 1'b0});
        wait_ack(a, rd, er, waited);
        bus.req[2] = 1'b0;
        e = exp_q.pop_front(); exp_ack = '0; exp_ack[e.idx] = 1'b1;
        n_checks++; if (a !== exp_ack || rd !== e.rdata || waited != 2) begin n_fail++;
            $display("FAIL rstmid_after: got ack=%b rd=%b lat=%0d want ack=%b rd=%b lat=2",
                a, rd, waited, exp_ack, e.rdata); end
        @(negedge clk);
    endtask

    task automatic test_rr_pointer();
        logic [NUM_REQ-1:0] a, exp_ack;
        logic rd, er;
        int   waited;
        exp_t e;
        set_req(0, 1'b1, 4'd3, 1'b0);
        set_req(2, 1'b1, 4'd9, 1'b0);
        exp_q.push_back('{0, exp_mem[3], 1'b1, 1'b0});
        exp_q.push_back('{2, exp_mem[9], 1'b1, 1'b0});
        for (int k = 0; k < 2; k++) begin
            wait_ack(a, rd, er, waited);
            bus.req = bus.req & ~a;
            e = exp_q.pop_front(); exp_ack = '0; exp_ack[e.idx] = 1'b1;
            n_checks++; if (a !== exp_ack || rd !== e.rdata || waited != 2 + k) begin n_fail++;
                $display("FAIL rr_order%0d: got ack=%b rd=%b lat=%0d want ack=%b rd=%b lat=%0d",
                    k, a, rd, waited, exp_ack, e.rdata, 2 + k); end
        end
        bus.req = '0;
        @(negedge clk);
        n_checks++; if (bus.busy !== 1'b0 || exp_q.size() != 0) begin n_fail++;
            $display("FAIL rr_idle: got busy=%b pending=%0d want busy=0 pending=0",
                bus.busy, exp_q.size()); end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_contention();
        test_illegal();
        test_glitch();
        test_reset_mid_write();
        test_rr_pointer();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1, "watchdog");
    end
endmodule
